// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a 4x16 register file's single read and write port.
// A 3-state sequencer (ARB -> ACCESS -> RESP) services one transaction at a time.
// Optional: define REGARB_LOCK_EN to add a lock input and a LOCKED state that
// keeps the port for one requester, giving atomic read-modify-write.
module regfile_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*IDX_W-1:0]  idx,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef REGARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [IDX_W-1:0]          rf_read_index,
  input  logic [DATA_W-1:0]         rf_read_data,
  output logic [IDX_W-1:0]          rf_write_index,
  output logic                      rf_write_enable,
  output logic [DATA_W-1:0]         rf_write_data
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef REGARB_LOCK_EN
  typedef enum logic [1:0] {StArb, StAccess, StResp, StLocked} state_e;
`else
  typedef enum logic [1:0] {StArb, StAccess, StResp} state_e;
`endif

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                found;
  logic [ID_W-1:0]     pick;
  logic [ID_W-1:0]     cand;
  logic                load;
  logic [ID_W-1:0]     load_id;

  // Round-robin search: first requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Sequencer next-state, field latching and all port outputs.
  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    id_d            = id_q;
    we_d            = we_q;
    idx_d           = idx_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    load            = 1'b0;
    load_id         = pick;
    gnt             = '0;
    done            = '0;
    busy            = 1'b0;
    rf_read_index   = '0;
    rf_write_index  = '0;
    rf_write_enable = 1'b0;
    rf_write_data   = '0;

    case (state_q)
      StArb: begin
        if (found) begin
          load    = 1'b1;
          load_id = pick;
          state_d = StAccess;
        end
      end
      StAccess: begin
        gnt[id_q]       = 1'b1;
        busy            = 1'b1;
        rf_read_index   = idx_q;
        rf_write_index  = idx_q;
        rf_write_enable = we_q;
        rf_write_data   = wdata_q;
        if (!we_q) rdata_d = rf_read_data;
        // Advancing here also yields the id+1 pointer a LOCKED exit requires.
        rr_d    = (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
        state_d = StResp;
      end
      StResp: begin
        done[id_q] = 1'b1;
        busy       = 1'b1;
        state_d    = StArb;
`ifdef REGARB_LOCK_EN
        if (lock[id_q]) state_d = StLocked;
`endif
      end
`ifdef REGARB_LOCK_EN
      StLocked: begin
        if (!lock[id_q]) begin
          state_d = StArb;
        end else if (req[id_q]) begin
          load    = 1'b1;
          load_id = id_q;
          state_d = StAccess;
        end
      end
`endif
      default: state_d = StArb;
    endcase

    if (load) begin
      id_d    = load_id;
      we_d    = we[load_id];
      idx_d   = idx[load_id*IDX_W +: IDX_W];
      wdata_d = wdata[load_id*DATA_W +: DATA_W];
    end
  end

  assign rdata = rdata_q;

  // State registers; reset aborts any transaction at once, dropping every output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StArb;
      rr_q    <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter with a 4x16 register file model.
// Build with REGARB_LOCK_EN defined to also exercise the lock feature.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we;
  logic [5:0]  idx;
  logic [47:0] wdata;
  logic [2:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  rf_read_index, rf_write_index;
  logic [15:0] rf_read_data, rf_write_data;
  logic        rf_write_enable;
`ifdef REGARB_LOCK_EN
  logic [2:0]  lock;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  regfile_arbiter #(.NUM_REQ(3), .DATA_W(16), .IDX_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .we              (we),
    .idx             (idx),
    .wdata           (wdata),
`ifdef REGARB_LOCK_EN
    .lock            (lock),
`endif
    .gnt             (gnt),
    .done            (done),
    .rdata           (rdata),
    .busy            (busy),
    .rf_read_index   (rf_read_index),
    .rf_read_data    (rf_read_data),
    .rf_write_index  (rf_write_index),
    .rf_write_enable (rf_write_enable),
    .rf_write_data   (rf_write_data)
  );

  // Register file: combinational read, write on posedge.
  logic [15:0] rf [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  assign rf_read_data = rf[rf_read_index];
  always @(posedge clk) if (rf_write_enable) rf[rf_write_index] <= rf_write_data;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One transaction from a single requester; exp_rd is rdata expected at done.
  task automatic txn(input int r, input logic w, input logic [1:0] i, input logic [15:0] d,
                     input logic [15:0] exp_rd);
    int n = 0;
    req[r] = 1'b1;
    we[r]  = w;
    idx[r*2 +: 2]    = i;
    wdata[r*16 +: 16] = d;
    do begin
      tick();
      n++;
    end while (gnt[r] !== 1'b1 && n < 10);
    check($sformatf("txn r%0d gnt", r), 32'(gnt), 32'(1) << r);
    // Fields changed after the sample must not reach the register file.
    req[r] = 1'b0;
    we[r]  = ~w;
    idx[r*2 +: 2]    = ~i;
    wdata[r*16 +: 16] = ~d;
    check($sformatf("txn r%0d we", r), 32'(rf_write_enable), 32'(w));
    if (w) begin
      check($sformatf("txn r%0d widx", r), 32'(rf_write_index), 32'(i));
      check($sformatf("txn r%0d wdata", r), 32'(rf_write_data), 32'(d));
    end else begin
      check($sformatf("txn r%0d ridx", r), 32'(rf_read_index), 32'(i));
    end
    tick();
    check($sformatf("txn r%0d done", r), 32'(done), 32'(1) << r);
    check($sformatf("txn r%0d rdata", r), 32'(rdata), 32'(exp_rd));
    tick();
  endtask

  initial begin
    reset = 1'b0;
    req   = 3'b111;
    we    = 3'b000;
    idx   = '0;
    wdata = '0;
`ifdef REGARB_LOCK_EN
    lock  = 3'b000;
`endif

    // Reset held with all requests pending: everything stays quiet.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst gnt", 32'(gnt), 0);
      check("rst done", 32'(done), 0);
      check("rst busy", 32'(busy), 0);
      check("rst we", 32'(rf_write_enable), 0);
      check("rst rdata", 32'(rdata), 0);
    end
    reset = 1'b1;
    tick();
    check("first gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    check("first done", 32'(done), 32'b001);
    tick();
    check("idle busy", 32'(busy), 0);

    // Write then read-back by another requester; writes leave rdata alone.
    txn(0, 1'b1, 2'd2, 16'hBEEF, 16'h0000);
    txn(1, 1'b0, 2'd2, 16'h0000, 16'hBEEF);
    txn(0, 1'b1, 2'd0, 16'h1111, 16'hBEEF);
    txn(1, 1'b1, 2'd1, 16'h2222, 16'hBEEF);
    txn(2, 1'b1, 2'd2, 16'h3333, 16'hBEEF);

    // All three read continuously: grants 0,1,2,0 three cycles apart.
    req = 3'b111;
    we  = 3'b000;
    idx = {2'd2, 2'd1, 2'd0};
    for (int k = 0; k < 4; k++) begin
      logic [15:0] expv;
      int r;
      r = k % 3;
      expv = (r == 0) ? 16'h1111 : (r == 1) ? 16'h2222 : 16'h3333;
      tick();
      check($sformatf("rr%0d gnt", k), 32'(gnt), 32'(1) << r);
      tick();
      check($sformatf("rr%0d done", k), 32'(done), 32'(1) << r);
      check($sformatf("rr%0d rdata", k), 32'(rdata), 32'(expv));
      if (k == 3) req = 3'b000;
      tick();
      check($sformatf("rr%0d arb", k), 32'(busy), 0);
    end

    // Reset during a write's ACCESS cycle: no commit, no done, rdata cleared.
    req[2] = 1'b1;
    we[2]  = 1'b1;
    idx[5:4]    = 2'd1;
    wdata[47:32] = 16'hAAAA;
    tick();
    check("abort gnt", 32'(gnt), 32'b100);
    check("abort we pre", 32'(rf_write_enable), 1);
    #2 reset = 1'b0;
    req = 3'b000;
    #1;
    check("abort we now", 32'(rf_write_enable), 0);
    check("abort gnt now", 32'(gnt), 0);
    tick();
    check("abort done", 32'(done), 0);
    check("abort rf1", 32'(rf[1]), 32'h2222);
    check("abort rdata", 32'(rdata), 0);
    reset = 1'b1;
    // idx 1 still holds its earlier value 0x2222.
    txn(0, 1'b0, 2'd1, 16'h0000, 16'h2222);

`ifdef REGARB_LOCK_EN
    // Locked read-modify-write of reg 3 by requester 0 while requester 1 waits.
    req[0] = 1'b1;
    we[0]  = 1'b0;
    idx[1:0] = 2'd3;
    lock[0] = 1'b1;
    tick();
    check("lk rd gnt", 32'(gnt), 32'b001);
    req[0] = 1'b0;
    req[1] = 1'b1;
    we[1]  = 1'b0;
    idx[3:2] = 2'd3;
    tick();
    check("lk rd done", 32'(done), 32'b001);
    check("lk rd rdata", 32'(rdata), 32'h0000);
    tick();
    check("lk hold1 gnt", 32'(gnt), 0);
    tick();
    check("lk hold2 gnt", 32'(gnt), 0);
    req[0] = 1'b1;
    we[0]  = 1'b1;
    wdata[15:0] = 16'h0001;
    tick();
    check("lk wr gnt", 32'(gnt), 32'b001);
    check("lk wr data", 32'(rf_write_data), 32'h0001);
    req[0]  = 1'b0;
    lock[0] = 1'b0;
    tick();
    check("lk wr done", 32'(done), 32'b001);
    tick();
    check("lk arb gnt", 32'(gnt), 0);
    tick();
    check("lk r1 gnt", 32'(gnt), 32'b010);
    req[1] = 1'b0;
    tick();
    check("lk r1 done", 32'(done), 32'b010);
    check("lk r1 rdata", 32'(rdata), 32'h0001);
    check("lk rf3", 32'(rf[3]), 32'h0001);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
